prio_encoder_rr: RTL

Parametrised, registered priority encoder with a valid/ready handshake on both sides and a selectable round-robin mode. It accepts an N-bit request vector and returns the index of the winning request one cycle later, together with an "any request" flag. It is the general-width successor of the team's 3-input behavioural encoder. It sits between request sources and any downstream consumer that needs a single selected index with backpressure.

---
 rtl/prio_encoder_rr.sv | 95 +++++++++
 1 files changed

// File: rtl/prio_encoder_rr.sv
// Registered N-input priority encoder with valid/ready on both sides.
// Supports fixed priority (highest index wins) and round-robin mode.
module prio_encoder_rr #(
    parameter int unsigned N    = 8,
    parameter int unsigned IDXW = 3
) (
    input  logic            clk,
    input  logic            rst,
    input  logic [N-1:0]    req,
    input  logic            mode,
    input  logic            in_valid,
    output logic            in_ready,
    output logic [IDXW-1:0] out_idx,
    output logic            out_any,
    output logic            out_valid,
    input  logic            out_ready
);

    localparam logic [IDXW-1:0] LAST_IDX = IDXW'(N - 1);

    if (N < 2 || N > 64 || IDXW != $clog2(N)) begin : g_bad_params
        $error("prio_encoder_rr: N must be 2..64 and IDXW must equal clog2(N)");
    end

    logic [IDXW-1:0] ptr_q, ptr_d;
    logic [IDXW-1:0] out_idx_q, out_idx_d;
    logic            out_any_q, out_any_d;
    logic            out_valid_q, out_valid_d;

    logic [IDXW-1:0] fix_idx;
    logic            fix_hit;
    logic [IDXW-1:0] low_idx;
    logic            low_hit;
    logic [IDXW-1:0] rr_idx;
    logic            accept;

    // Round-robin order ptr, ptr-1, ..., 0, N-1, ..., ptr+1 equals: highest set
    // bit at or below ptr, otherwise the highest set bit overall.
    always_comb begin
        fix_idx = '0;
        fix_hit = 1'b0;
        low_idx = '0;
        low_hit = 1'b0;
        for (int unsigned i = 0; i < N; i++) begin
            if (req[i]) begin
                fix_idx = IDXW'(i);
                fix_hit = 1'b1;
                if (IDXW'(i) <= ptr_q) begin
                    low_idx = IDXW'(i);
                    low_hit = 1'b1;
                end
            end
        end
        rr_idx = low_hit ? low_idx : fix_idx;
    end

    always_comb begin
        in_ready    = !out_valid_q || out_ready;
        accept      = in_valid && in_ready;
        ptr_d       = ptr_q;
        out_idx_d   = out_idx_q;
        out_any_d   = out_any_q;
        out_valid_d = out_valid_q;
        if (accept) begin
            out_valid_d = 1'b1;
            out_any_d   = fix_hit;
            out_idx_d   = mode ? rr_idx : fix_idx;
            // Granted index becomes lowest priority; wrap at N-1, not 2^IDXW-1.
            if (mode && fix_hit) begin
                ptr_d = (rr_idx == '0) ? LAST_IDX : rr_idx - IDXW'(1);
            end
        end else if (out_ready) begin
            out_valid_d = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            ptr_q       <= LAST_IDX;
            out_idx_q   <= '0;
            out_any_q   <= 1'b0;
            out_valid_q <= 1'b0;
        end else begin
            ptr_q       <= ptr_d;
            out_idx_q   <= out_idx_d;
            out_any_q   <= out_any_d;
            out_valid_q <= out_valid_d;
        end
    end

    assign out_idx   = out_idx_q;
    assign out_any   = out_any_q;
    assign out_valid = out_valid_q;

endmodule
